sram_like_slave: RTL and testbench

- Responder end of the sram-like bus the core drives on its inst and data ports.
- Accepts requests (req/wr/size/addr/wdata) and answers with addr_ok and data_ok/rdata, strictly in order.
- Backed by a synchronous single-port RAM with 1-cycle read latency; latency is configurable.
- Used as the bench/SoC memory model for both the inst and data ports.

---
 rtl/sram_like_slave_pkg.sv | 27 ++
 rtl/sram_like_slave_resp_pipe.sv | 26 ++
 rtl/sram_like_slave.sv | 96 +++++++++
 tb/tb_sram_like_slave.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_slave_pkg.sv
// Shared types and helpers for the sram-like bus responder.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] data;
  } resp_t;

  // Returns {illegal, wen[3:0]}; wen is zero whenever the access is illegal.
  function automatic logic [4:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [4:0] m;
    m = 5'b1_0000;
    case (size)
      SIZE_BYTE: m = {1'b0, 4'b0001 << addr_lo};
      SIZE_HALF: if (!addr_lo[0]) m = {1'b0, addr_lo[1] ? 4'b1100 : 4'b0011};
      SIZE_WORD: if (addr_lo == 2'b00) m = 5'b0_1111;
      default:   m = 5'b1_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_like_slave_resp_pipe.sv
// Registered delay line for responses: one capture stage plus LATENCY extra stages.
module resp_pipe
  import sram_like_pkg::*;
#(
  parameter int LATENCY = 0
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t capture,
  output resp_t resp
);

  resp_t stg [LATENCY:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= LATENCY; i++) stg[i] <= '0;
    end else begin
      stg[0] <= capture;
      for (int i = 1; i <= LATENCY; i++) stg[i] <= stg[i-1];
    end
  end

  assign resp = stg[LATENCY];

endmodule

// File: rtl/sram_like_slave.sv
// In-order sram-like bus responder over a 1-cycle synchronous RAM.
// Optional SRAM_SLAVE_RAND_STALL_EN: LFSR-driven random addr_ok stalls.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int LATENCY   = 0,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  logic [CW-1:0] cnt;
  logic [4:0]    mask;
  logic          accepted;
  logic          stall;
  logic          s0_valid, s0_illegal, s0_zero;
  resp_t         capture, resp;
  logic          unused_bits;

`ifdef SRAM_SLAVE_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // A retiring response frees a slot in the same cycle, so full-rate issue holds at the limit.
  assign addr_ok  = rst & ~stall & ((cnt < MAX_CNT) | data_ok);
  assign accepted = req & addr_ok;
  assign mask     = byte_mask(size, addr[1:0]);

  assign ram_en    = accepted;
  assign ram_addr  = addr[ADDR_W+1:2];
  assign ram_wdata = wdata;
  assign ram_wen   = (accepted & wr) ? mask[3:0] : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid   <= 1'b0;
      s0_illegal <= 1'b0;
      s0_zero    <= 1'b0;
      cnt        <= '0;
    end else begin
      s0_valid   <= accepted;
      s0_illegal <= mask[4];
      s0_zero    <= mask[4] | wr;
      cnt        <= cnt + CW'(accepted) - CW'(data_ok);
    end
  end

  // ram_rdata belongs to the request sitting in stage 0; writes and illegal accesses answer 0.
  always_comb begin
    capture         = '0;
    capture.valid   = s0_valid;
    capture.illegal = s0_illegal;
    capture.data    = s0_zero ? 32'h0 : ram_rdata;
  end

  resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .resp    (resp)
  );

  assign data_ok = resp.valid;
  assign rdata   = resp.valid ? resp.data : 32'h0;

  assign unused_bits = ^{addr[31:ADDR_W+2], resp.illegal};

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: two instances (short and long latency) against a scoreboard model.
module tb_sram_like_slave;

  localparam int LATS[2] = '{0, 4};
  localparam int MOS[2]  = '{4, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]        req, wr, addr_ok, data_ok, ram_en;
  logic [1:0][1:0]   size;
  logic [1:0][31:0]  addr, wdata, rdata, ram_wdata, ram_rdata;
  logic [1:0][3:0]   ram_wen;
  logic [1:0][15:0]  ram_addr;

  int errors = 0, checks = 0, cyc = 0, stalls = 0, live = 0;
  int acc_n[2], dok_n[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_slave #(.ADDR_W(16), .LATENCY(LATS[0]), .MAX_OUTST(MOS[0])) u0 (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
    .ram_en(ram_en[0]), .ram_wen(ram_wen[0]), .ram_addr(ram_addr[0]),
    .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]));

  sram_like_slave #(.ADDR_W(16), .LATENCY(LATS[1]), .MAX_OUTST(MOS[1])) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
    .ram_en(ram_en[1]), .ram_wen(ram_wen[1]), .ram_addr(ram_addr[1]),
    .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]));

  // Backing RAMs (all traffic stays inside the first 64 bytes).
  logic [31:0] mem [2][16] = '{default: '0};
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[d][b]) mem[d][ram_addr[d][3:0]][8*b +: 8] <= ram_wdata[d][8*b +: 8];
        ram_rdata[d] <= mem[d][ram_addr[d][3:0]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", nm, cyc);
  endtask

  // Scoreboard: a word-array memory image and a FIFO of expected responses with due cycles.
  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t        q[2][$];
  logic [31:0] mdl [2][16] = '{default: '0};
  logic        ok_exp, ill;
  int          w, o;
  logic [31:0] val;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        q[d].delete();
        acc_n[d] = 0;
        dok_n[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        ok_exp = (q[d].size() < MOS[d]) || data_ok[d];
`ifdef SRAM_SLAVE_RAND_STALL_EN
        chk("addr_ok_bound", {31'b0, addr_ok[d] & ~ok_exp}, 32'h0);
        if (d == 0) begin
          live++;
          if (!addr_ok[0]) stalls++;
        end
`else
        chk($sformatf("addr_ok_u%0d", d), {31'b0, addr_ok[d]}, {31'b0, ok_exp});
`endif
        if (data_ok[d]) begin
          dok_n[d]++;
          if (q[d].size() == 0) fail($sformatf("spurious_data_ok_u%0d", d));
          else begin
            chk($sformatf("dok_time_u%0d", d), cyc, q[d][0].due);
            chk($sformatf("rdata_u%0d", d), rdata[d], q[d][0].data);
            void'(q[d].pop_front());
          end
        end else if (q[d].size() != 0 && q[d][0].due <= cyc) begin
          fail($sformatf("missing_data_ok_u%0d", d));
          void'(q[d].pop_front());
        end
        if (req[d] && addr_ok[d]) begin
          acc_n[d]++;
          w   = int'(addr[d][5:2]);
          o   = int'(addr[d][1:0]);
          ill = (size[d] == 2'd3) || (size[d] == 2'd1 && addr[d][0]) ||
                (size[d] == 2'd2 && addr[d][1:0] != 2'd0);
          val = 32'h0;
          if (wr[d]) begin
            if (!ill) begin
              case (size[d])
                2'd0:    mdl[d][w][8*o +: 8]  = wdata[d][8*o +: 8];
                2'd1:    mdl[d][w][8*o +: 16] = wdata[d][8*o +: 16];
                default: mdl[d][w]            = wdata[d];
              endcase
            end
          end else if (!ill) val = mdl[d][w];
          q[d].push_back('{cyc + 2 + LATS[d], val});
        end
        chk($sformatf("cnt_bound_u%0d", d), {31'b0, q[d].size() <= MOS[d]}, 32'h1);
      end
    end
  end

  task automatic drive(input int d, input logic r, input logic w_, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    req[d] = r; wr[d] = w_; size[d] = s; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) drive(d, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic rd_check(input int d, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] exp, input string nm);
    bit got;
    got = 1'b0;
    drive(d, 1'b1, 1'b0, s, a, 32'h0);
    for (int i = 0; i < 12 && !got; i++) begin
      idle(d, 1);
      if (data_ok[d]) begin
        got = 1'b1;
        chk(nm, rdata[d], exp);
      end
    end
    if (!got) fail({nm, "_timeout"});
  endtask

  typedef struct { logic w; logic [1:0] sz; logic [31:0] a; logic [31:0] wd; logic [3:0] wen; } vec_t;
  vec_t       vt[10];
  logic [6:0] pat;

  initial begin
    req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
    vt[0] = '{1'b1, 2'd2, 32'h20, 32'h00000000, 4'hf};
    vt[1] = '{1'b1, 2'd0, 32'h23, 32'hAA000000, 4'h8};
    vt[2] = '{1'b1, 2'd1, 32'h20, 32'h00005555, 4'h3};
    vt[3] = '{1'b1, 2'd1, 32'h21, 32'hFFFFFFFF, 4'h0};
    vt[4] = '{1'b1, 2'd3, 32'h20, 32'hFFFFFFFF, 4'h0};
    vt[5] = '{1'b1, 2'd0, 32'h25, 32'h0000BB00, 4'h2};
    vt[6] = '{1'b1, 2'd1, 32'h26, 32'hCCCC0000, 4'hc};
    vt[7] = '{1'b1, 2'd2, 32'h2A, 32'h12345678, 4'h0};
    vt[8] = '{1'b0, 2'd2, 32'h20, 32'h00000000, 4'h0};
    vt[9] = '{1'b0, 2'd0, 32'h24, 32'h00000000, 4'h0};

    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_addr_ok", {31'b0, addr_ok[d]}, 32'h0);
      chk("rst_data_ok", {31'b0, data_ok[d]}, 32'h0);
      chk("rst_ram_en",  {31'b0, ram_en[d]},  32'h0);
      chk("rst_ram_wen", {28'b0, ram_wen[d]}, 32'h0);
      chk("rst_rdata",   rdata[d], 32'h0);
    end
    #1 rst = 1'b1;

`ifndef SRAM_SLAVE_RAND_STALL_EN
    // Word write then back-to-back read of the same word.
    drive(0, 1'b1, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    chk("ww_wen", {28'b0, ram_wen[0]}, 32'hf);
    chk("ww_en", {31'b0, ram_en[0]}, 32'h1);
    drive(0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    chk("wr_rd_wen", {28'b0, ram_wen[0]}, 32'h0);
    chk("wr_dok_early", {31'b0, data_ok[0]}, 32'h0);
    idle(0, 1);
    chk("wr_dok", {31'b0, data_ok[0]}, 32'h1);
    chk("wr_rdata", rdata[0], 32'h0);
    idle(0, 1);
    chk("raw_dok", {31'b0, data_ok[0]}, 32'h1);
    chk("raw_rdata", rdata[0], 32'hDEADBEEF);
    idle(0, 2);

    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, vt[i].w, vt[i].sz, vt[i].a, vt[i].wd);
      chk($sformatf("vec%0d_wen", i), {28'b0, ram_wen[0]}, {28'b0, vt[i].wen});
      chk($sformatf("vec%0d_en", i), {31'b0, ram_en[0]}, 32'h1);
    end
    idle(0, 4);
    rd_check(0, 2'd2, 32'h20, 32'hAA005555, "lane_rd20");
    rd_check(0, 2'd2, 32'h24, 32'hCCCCBB00, "lane_rd24");
    rd_check(0, 2'd2, 32'h28, 32'h00000000, "ill_word_no_write");
    rd_check(0, 2'd1, 32'h21, 32'h00000000, "ill_half_rd");
    rd_check(0, 2'd3, 32'h20, 32'h00000000, "ill_size3_rd");

    // Back-pressure on the LATENCY=4, MAX_OUTST=2 instance.
    pat = 7'b1000011;
    for (int i = 0; i < 7; i++) begin
      drive(1, 1'b1, 1'b0, 2'd2, 32'(4 * i), 32'h0);
      chk($sformatf("bp_addr_ok%0d", i), {31'b0, addr_ok[1]}, {31'b0, pat[i]});
    end
    for (int i = 0; i < 6; i++) drive(1, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    idle(1, 10);
    chk("bp_dok_eq_acc", dok_n[1], acc_n[1]);

    // Reset one cycle before the first response of two accepted reads.
    drive(0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    drive(0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
    #2 rst = 1'b0; req = '0;
    #1;
    chk("mid_rst_addr_ok", {31'b0, addr_ok[0]}, 32'h0);
    chk("mid_rst_ram_en", {31'b0, ram_en[0]}, 32'h0);
    chk("mid_rst_data_ok", {31'b0, data_ok[0]}, 32'h0);
    chk("mid_rst_rdata", rdata[0], 32'h0);
    @(posedge clk); #2 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(0, 1);
      chk("post_rst_data_ok", {31'b0, data_ok[0]}, 32'h0);
      chk("post_rst_addr_ok", {31'b0, addr_ok[0]}, 32'h1);
    end
`endif

    // Randomized traffic on both instances against the scoreboard.
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        req[d]   = ($urandom_range(0, 3) != 0);
        wr[d]    = 1'($urandom_range(0, 1));
        size[d]  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        addr[d]  = 32'($urandom_range(0, 63));
        wdata[d] = $urandom;
      end
    end
    @(posedge clk); #1 req = '0;
    idle(0, 12);
    chk("rand_dok_eq_acc_u0", dok_n[0], acc_n[0]);
    chk("rand_dok_eq_acc_u1", dok_n[1], acc_n[1]);
    chk("rand_drained_u0", q[0].size(), 32'h0);
    chk("rand_drained_u1", q[1].size(), 32'h0);
`ifdef SRAM_SLAVE_RAND_STALL_EN
    if (live == 0 || stalls * 100 < live * 15 || stalls * 100 > live * 35) fail("stall_ratio");
    else checks++;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
